// File: rtl/param_index_counter_pkg.sv
// Shared definitions for the digital-lock index counter: end-of-range modes,
// lock-level default digit-count geometry and the per-edge command decode.
package param_index_counter_pkg;

  localparam int CNT_SAT  = 0;
  localparam int CNT_WRAP = 1;

  localparam int LOCK_DIGIT_WIDTH = 3;
  localparam int LOCK_DIGIT_MAX   = 7;

  typedef enum logic [2:0] {
    CMD_HOLD,
    CMD_CLR,
    CMD_LOAD,
    CMD_INC,
    CMD_DEC
  } cmd_e;

  // Resolves the clr > load > (inc XOR dec) > hold priority for one edge.
  function automatic cmd_e decodeCmd(input logic clr, input logic load,
                                     input logic inc, input logic dec);
    cmd_e cmd;
    cmd = CMD_HOLD;
    if (clr)
      cmd = CMD_CLR;
    else if (load)
      cmd = CMD_LOAD;
    else if (inc && !dec)
      cmd = CMD_INC;
    else if (dec && !inc)
      cmd = CMD_DEC;
    return cmd;
  endfunction

endpackage

// File: rtl/param_index_counter.sv
// Parametrised up/down index counter with saturate or wrap range ends, load with
// silent clamp, synchronous clear and registered boundary event pulses.
module param_index_counter
  import param_index_counter_pkg::*;
#(
  parameter int WIDTH   = LOCK_DIGIT_WIDTH,
  parameter int MAX_VAL = LOCK_DIGIT_MAX,
  parameter int STEP    = 1,
  parameter int WRAP    = CNT_SAT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             inc,
  input  logic             dec,
  output logic [WIDTH-1:0] index,
  output logic             at_max,
  output logic             at_min,
  output logic             sat_hit,
  output logic             wrapped
);

  // Range arithmetic is one bit wider so index+STEP cannot overflow before compare.
  localparam logic [WIDTH:0]   MAX_EXT  = (WIDTH+1)'(MAX_VAL);
  localparam logic [WIDTH:0]   STEP_EXT = (WIDTH+1)'(STEP);
  localparam logic [WIDTH:0]   MOD_EXT  = (WIDTH+1)'(MAX_VAL + 1);
  localparam logic [WIDTH-1:0] MAX_W    = WIDTH'(MAX_VAL);
  localparam bit               IS_WRAP  = (WRAP == CNT_WRAP);

  logic [WIDTH-1:0] r_index;
  logic             r_event;

  cmd_e             w_cmd;
  logic [WIDTH:0]   w_idxExt;
  logic [WIDTH:0]   w_sum;
  logic             w_upOver;
  logic             w_downUnder;
  logic [WIDTH-1:0] w_nextIndex;
  logic             w_nextEvent;

  assign w_cmd       = decodeCmd(clr, load, inc, dec);
  assign w_idxExt    = {1'b0, r_index};
  assign w_sum       = w_idxExt + STEP_EXT;
  assign w_upOver    = (w_sum > MAX_EXT);
  assign w_downUnder = (w_idxExt < STEP_EXT);

  always_comb begin
    w_nextIndex = r_index;
    w_nextEvent = 1'b0;
    unique case (w_cmd)
      CMD_CLR: begin
        w_nextIndex = '0;
      end
      CMD_LOAD: begin
        w_nextIndex = (load_val > MAX_W) ? MAX_W : load_val;
      end
      CMD_INC: begin
        if (w_upOver) begin
          w_nextEvent = 1'b1;
          w_nextIndex = IS_WRAP ? WIDTH'(w_sum - MOD_EXT) : MAX_W;
        end else begin
          w_nextIndex = WIDTH'(w_sum);
        end
      end
      CMD_DEC: begin
        if (w_downUnder) begin
          w_nextEvent = 1'b1;
          w_nextIndex = IS_WRAP ? WIDTH'(w_idxExt + MOD_EXT - STEP_EXT) : '0;
        end else begin
          w_nextIndex = WIDTH'(w_idxExt - STEP_EXT);
        end
      end
      default: begin
        w_nextIndex = r_index;
        w_nextEvent = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_index <= '0;
      r_event <= 1'b0;
    end else begin
      r_index <= w_nextIndex;
      r_event <= w_nextEvent;
    end
  end

  // One event register serves both pulses; the build mode picks which one it drives.
  assign index   = r_index;
  assign at_max  = (r_index == MAX_W);
  assign at_min  = (r_index == '0);
  assign sat_hit = !IS_WRAP && r_event;
  assign wrapped = IS_WRAP && r_event;

endmodule

// File: tb/tb_param_index_counter.sv
// Bench for param_index_counter: default build, a WRAP=1 9/3 build and a WRAP=0 9/3
// build share one stimulus stream, checked against tables and a range-rule model.
module tb_param_index_counter;

  logic       clk = 1'b0;
  logic       rst;
  logic       clr;
  logic       load;
  logic [3:0] lv4;
  logic [2:0] lv3;
  logic       inc;
  logic       dec;

  logic [2:0] idx0;
  logic       max0, min0, sat0, wrp0;
  logic [3:0] idx1;
  logic       max1, min1, sat1, wrp1;
  logic [3:0] idx2;
  logic       max2, min2, sat2, wrp2;

  int checks   = 0;
  int failures = 0;

  int m0, m1, m2;
  bit ms0, mw1, ms2;

  typedef struct {
    bit c;
    bit l;
    int lv;
    bit i;
    bit d;
    int e0;
    bit s0;
    int e1;
    bit w1;
  } vec_t;

  vec_t vecs[$];

  assign lv3 = lv4[2:0];

  always #5 clk = ~clk;

  param_index_counter #(.WIDTH(3), .MAX_VAL(7), .STEP(1), .WRAP(0)) dut0 (
    .clk(clk), .rst(rst), .clr(clr), .load(load), .load_val(lv3),
    .inc(inc), .dec(dec), .index(idx0), .at_max(max0), .at_min(min0),
    .sat_hit(sat0), .wrapped(wrp0)
  );

  param_index_counter #(.WIDTH(4), .MAX_VAL(9), .STEP(3), .WRAP(1)) dut1 (
    .clk(clk), .rst(rst), .clr(clr), .load(load), .load_val(lv4),
    .inc(inc), .dec(dec), .index(idx1), .at_max(max1), .at_min(min1),
    .sat_hit(sat1), .wrapped(wrp1)
  );

  param_index_counter #(.WIDTH(4), .MAX_VAL(9), .STEP(3), .WRAP(0)) dut2 (
    .clk(clk), .rst(rst), .clr(clr), .load(load), .load_val(lv4),
    .inc(inc), .dec(dec), .index(idx2), .at_max(max2), .at_min(min2),
    .sat_hit(sat2), .wrapped(wrp2)
  );

  // Reference: the range rules applied with plain integer arithmetic.
  function automatic int modelNext(input int idx, input bit c, input bit l, input int lv,
                                   input bit i, input bit d, input int maxv, input int step,
                                   input bit wrapMode, output bit ev);
    int t;
    ev = 1'b0;
    if (c) return 0;
    if (l) return (lv > maxv) ? maxv : lv;
    if (i && !d) begin
      t = idx + step;
      if (t > maxv) begin
        ev = 1'b1;
        return wrapMode ? t - (maxv + 1) : maxv;
      end
      return t;
    end
    if (d && !i) begin
      t = idx - step;
      if (t < 0) begin
        ev = 1'b1;
        return wrapMode ? t + (maxv + 1) : 0;
      end
      return t;
    end
    return idx;
  endfunction

  function automatic vec_t mkVec(input bit c, input bit l, input int lv, input bit i,
                                 input bit d, input int e0, input bit s0, input int e1,
                                 input bit w1);
    vec_t v;
    v.c = c; v.l = l; v.lv = lv; v.i = i; v.d = d;
    v.e0 = e0; v.s0 = s0; v.e1 = e1; v.w1 = w1;
    return v;
  endfunction

  task automatic checkVal(input string name, input logic [31:0] actual,
                          input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic checkOutput(input string tag, input int e0, input bit p0,
                             input int e1, input bit p1, input int e2, input bit p2);
    checkVal({tag, ".idx0"}, 32'(idx0), e0);
    checkVal({tag, ".sat0"}, 32'(sat0), 32'(p0));
    checkVal({tag, ".wrp0"}, 32'(wrp0), 0);
    checkVal({tag, ".max0"}, 32'(max0), (e0 == 7) ? 1 : 0);
    checkVal({tag, ".min0"}, 32'(min0), (e0 == 0) ? 1 : 0);
    checkVal({tag, ".idx1"}, 32'(idx1), e1);
    checkVal({tag, ".wrp1"}, 32'(wrp1), 32'(p1));
    checkVal({tag, ".sat1"}, 32'(sat1), 0);
    checkVal({tag, ".max1"}, 32'(max1), (e1 == 9) ? 1 : 0);
    checkVal({tag, ".min1"}, 32'(min1), (e1 == 0) ? 1 : 0);
    checkVal({tag, ".idx2"}, 32'(idx2), e2);
    checkVal({tag, ".sat2"}, 32'(sat2), 32'(p2));
    checkVal({tag, ".wrp2"}, 32'(wrp2), 0);
    checkVal({tag, ".max2"}, 32'(max2), (e2 == 9) ? 1 : 0);
    checkVal({tag, ".min2"}, 32'(min2), (e2 == 0) ? 1 : 0);
  endtask

  // Drives one command at the falling edge and samples just after the next rising edge.
  task automatic applyStimulus(input bit c, input bit l, input int lv, input bit i, input bit d);
    @(negedge clk);
    clr  = c;
    load = l;
    lv4  = 4'(lv);
    inc  = i;
    dec  = d;
    m0 = modelNext(m0, c, l, lv & 7, i, d, 7, 1, 1'b0, ms0);
    m1 = modelNext(m1, c, l, lv, i, d, 9, 3, 1'b1, mw1);
    m2 = modelNext(m2, c, l, lv, i, d, 9, 3, 1'b0, ms2);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst  = 1'b0;
    clr  = 1'b0;
    load = 1'b0;
    lv4  = 4'd0;
    inc  = 1'b0;
    dec  = 1'b0;
    m0 = 0; m1 = 0; m2 = 0;
    ms0 = 1'b0; mw1 = 1'b0; ms2 = 1'b0;

    // Default build counts 0..7 then saturates; wrap build steps 3,6,9,2,...
    for (int k = 0; k < 9; k++) vecs.push_back(mkVec(0, 0, 0, 1, 0, 0, 0, 0, 0));
    vecs[0].e0 = 1; vecs[0].e1 = 3;
    vecs[1].e0 = 2; vecs[1].e1 = 6;
    vecs[2].e0 = 3; vecs[2].e1 = 9;
    vecs[3].e0 = 4; vecs[3].e1 = 2; vecs[3].w1 = 1;
    vecs[4].e0 = 5; vecs[4].e1 = 5;
    vecs[5].e0 = 6; vecs[5].e1 = 8;
    vecs[6].e0 = 7; vecs[6].e1 = 1; vecs[6].w1 = 1;
    vecs[7].e0 = 7; vecs[7].s0 = 1; vecs[7].e1 = 4;
    vecs[8].e0 = 7; vecs[8].s0 = 1; vecs[8].e1 = 7;
    vecs.push_back(mkVec(0, 1, 2, 0, 0, 2, 0, 2, 0));
    vecs.push_back(mkVec(0, 0, 0, 0, 1, 1, 0, 9, 1));
    vecs.push_back(mkVec(0, 1, 7, 0, 0, 7, 0, 7, 0));
    vecs.push_back(mkVec(0, 0, 0, 0, 1, 6, 0, 4, 0));
    vecs.push_back(mkVec(0, 0, 0, 0, 1, 5, 0, 1, 0));
    vecs.push_back(mkVec(0, 0, 0, 0, 1, 4, 0, 8, 1));
    vecs.push_back(mkVec(0, 0, 0, 0, 1, 3, 0, 5, 0));
    vecs.push_back(mkVec(0, 0, 0, 0, 1, 2, 0, 2, 0));
    vecs.push_back(mkVec(0, 0, 0, 0, 1, 1, 0, 9, 1));
    vecs.push_back(mkVec(0, 0, 0, 0, 1, 0, 0, 6, 0));
    vecs.push_back(mkVec(0, 0, 0, 0, 1, 0, 1, 3, 0));
    vecs.push_back(mkVec(1, 1, 12, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mkVec(1, 0, 0, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mkVec(0, 1, 12, 0, 0, 4, 0, 9, 0));
    vecs.push_back(mkVec(0, 0, 0, 1, 1, 4, 0, 9, 0));
    vecs.push_back(mkVec(0, 1, 9, 1, 0, 1, 0, 9, 0));
    vecs.push_back(mkVec(0, 0, 0, 0, 0, 1, 0, 9, 0));

    #12;
    checkOutput("reset", 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b1;

    foreach (vecs[k]) begin
      applyStimulus(vecs[k].c, vecs[k].l, vecs[k].lv, vecs[k].i, vecs[k].d);
      checkOutput($sformatf("vec%0d", k), vecs[k].e0, vecs[k].s0,
                  vecs[k].e1, vecs[k].w1, m2, ms2);
    end

    for (int n = 0; n < 400; n++) begin
      applyStimulus(($urandom % 16) == 0, ($urandom % 8) == 0, int'($urandom % 16),
                    $urandom % 2 == 1, $urandom % 2 == 1);
      checkOutput($sformatf("rand%0d", n), m0, ms0, m1, mw1, m2, ms2);
    end

    // Reset asserted between edges clears at once and overrides a pending inc.
    applyStimulus(0, 1, 5, 0, 0);
    checkOutput("load5", 5, 0, 5, 0, 5, 0);
    #2;
    rst  = 1'b0;
    load = 1'b0;
    inc  = 1'b1;
    #1;
    checkOutput("rstMid", 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("rstRelease", 1, 0, 3, 0, 3, 0);
    @(negedge clk);
    inc = 1'b0;
    m0 = 1; m1 = 3; m2 = 3;
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("afterRst", m0, ms0, m1, mw1, m2, ms2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
